// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception sequencer: ex codes, CP0 register
// indices, FSM state encoding and the interrupt qualification helper.
package exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT    = 5'h00;
    localparam logic [4:0] EXC_HLT    = 5'h01;
    localparam logic [4:0] EXC_RESUME = 5'h02;
    localparam logic [4:0] EXC_ADEL   = 5'h04;
    localparam logic [4:0] EXC_ADES   = 5'h05;
    localparam logic [4:0] EXC_SYS    = 5'h08;
    localparam logic [4:0] EXC_BP     = 5'h09;
    localparam logic [4:0] EXC_RI     = 5'h0a;
    localparam logic [4:0] EXC_OV     = 5'h0c;

    localparam logic [4:0] CP0_STATUS = 5'd12;
    localparam logic [4:0] CP0_CAUSE  = 5'd13;
    localparam logic [4:0] CP0_EPC    = 5'd14;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_COMMIT = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALT   = 2'd3;

    typedef struct packed {
        logic [4:0]  code;
        logic [31:0] epc;
        logic        bd;
        logic        eret;
    } commit_t;

    // An interrupt is only taken while enabled, outside EXL and not halted.
    function automatic logic int_pending_f(input logic [7:0] sig, input logic [7:0] mask,
                                           input logic ie, input logic exl, input logic hlt);
        return (|(sig & mask)) & ie & ~exl & ~hlt;
    endfunction

endpackage

// File: rtl/exc_ctrl_prio.sv
// Combinational IDLE arbitration: picks which event (exception, interrupt,
// ERET or external resume) becomes the next commit and what it carries.
module exc_prio
    import exc_ctrl_pkg::*;
#(
    parameter logic [4:0] CODE_INT    = 5'h00,
    parameter logic [4:0] CODE_RESUME = 5'h02
) (
    input  logic        wb_valid,
    input  logic        wb_ex_req,
    input  logic [4:0]  wb_ex_code,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic        wb_eret,
    input  logic        int_pending,
    input  logic        cp0_hlt,
    input  logic        resume_req,
    output logic        take,
    output logic [4:0]  sel_code,
    output logic [31:0] sel_epc,
    output logic        sel_bd,
    output logic        sel_eret
);

    always_comb begin
        take     = 1'b0;
        sel_code = '0;
        sel_epc  = '0;
        sel_bd   = 1'b0;
        sel_eret = 1'b0;
        if (wb_valid && wb_ex_req) begin
            take     = 1'b1;
            sel_code = wb_ex_code;
            sel_epc  = wb_pc;
            sel_bd   = wb_bd;
        end else if (wb_valid && int_pending) begin
            // The WB instruction is not retired, so EPC points back at it.
            take     = 1'b1;
            sel_code = CODE_INT;
            sel_epc  = wb_pc;
            sel_bd   = wb_bd;
        end else if (wb_valid && wb_eret) begin
            take     = 1'b1;
            sel_eret = 1'b1;
        end else if (cp0_hlt && resume_req) begin
            take     = 1'b1;
            sel_code = CODE_RESUME;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: one registered commit to CP0, a fixed
// flush/stall drain window, and the halt/resume handshake.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int         FLUSH_CYCLES = 2,
    parameter logic [4:0] CODE_INT     = 5'h00,
    parameter logic [4:0] CODE_HLT     = 5'h01,
    parameter logic [4:0] CODE_RESUME  = 5'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic        wb_ex_req,
    input  logic [4:0]  wb_ex_code,
    input  logic [31:0] wb_pc,
    input  logic        wb_bd,
    input  logic        wb_eret,
    input  logic        cp0_ie,
    input  logic        cp0_exl,
    input  logic [7:0]  cp0_int_mask,
    input  logic [7:0]  cp0_int_sig,
    input  logic        cp0_hlt,
    input  logic        resume_req,
    output logic        ex_wb_out,
    output logic [4:0]  ex_code_out,
    output logic [31:0] epc_out,
    output logic        bd_out,
    output logic        eret_flush_out,
    output logic        pipe_flush,
    output logic        pipe_stall,
    output logic        busy
);

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    logic [1:0] state, state_n;
    logic [3:0] cnt, cnt_n;
    commit_t    lat, lat_n, sel;
    logic       take;
    logic       int_pending;
    logic       commit_n;
    logic       ex_n;

    assign int_pending = int_pending_f(cp0_int_sig, cp0_int_mask, cp0_ie, cp0_exl, cp0_hlt);

    exc_prio #(
        .CODE_INT    (CODE_INT),
        .CODE_RESUME (CODE_RESUME)
    ) u_prio (
        .wb_valid    (wb_valid),
        .wb_ex_req   (wb_ex_req),
        .wb_ex_code  (wb_ex_code),
        .wb_pc       (wb_pc),
        .wb_bd       (wb_bd),
        .wb_eret     (wb_eret),
        .int_pending (int_pending),
        .cp0_hlt     (cp0_hlt),
        .resume_req  (resume_req),
        .take        (take),
        .sel_code    (sel.code),
        .sel_epc     (sel.epc),
        .sel_bd      (sel.bd),
        .sel_eret    (sel.eret)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        lat_n   = lat;
        case (state)
            ST_IDLE: begin
                if (take) begin
                    state_n = ST_COMMIT;
                    lat_n   = sel;
                end
            end
            ST_COMMIT: begin
                state_n = ST_DRAIN;
                cnt_n   = CNT_LOAD;
            end
            ST_DRAIN: begin
                if (cnt == 4'd0) begin
                    state_n = (!lat.eret && lat.code == CODE_HLT) ? ST_HALT : ST_IDLE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_HALT: begin
                if (resume_req) begin
                    state_n    = ST_COMMIT;
                    lat_n.code = CODE_RESUME;
                    lat_n.epc  = '0;
                    lat_n.bd   = 1'b0;
                    lat_n.eret = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    assign commit_n = (state_n == ST_COMMIT);
    assign ex_n     = commit_n & ~lat_n.eret;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            ex_wb_out      <= 1'b0;
            ex_code_out    <= '0;
            epc_out        <= '0;
            bd_out         <= 1'b0;
            eret_flush_out <= 1'b0;
            pipe_flush     <= 1'b0;
            pipe_stall     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            ex_wb_out      <= ex_n;
            ex_code_out    <= ex_n ? lat_n.code : 5'd0;
            epc_out        <= ex_n ? lat_n.epc : 32'd0;
            bd_out         <= ex_n & lat_n.bd;
            eret_flush_out <= commit_n & lat_n.eret;
            pipe_flush     <= commit_n | (state_n == ST_DRAIN);
            pipe_stall     <= (state_n != ST_IDLE);
            busy           <= (state_n != ST_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        lat <= lat_n;
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: a window-timer model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_exc_ctrl;

    localparam int F = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid = 0, wb_ex_req = 0, wb_bd = 0, wb_eret = 0;
    logic [4:0]  wb_ex_code = 0;
    logic [31:0] wb_pc = 0;
    logic        cp0_ie = 0, cp0_exl = 0, cp0_hlt = 0, resume_req = 0;
    logic [7:0]  cp0_int_mask = 0, cp0_int_sig = 0;
    logic        ex_wb_out, bd_out, eret_flush_out, pipe_flush, pipe_stall, busy;
    logic [4:0]  ex_code_out;
    logic [31:0] epc_out;

    exc_ctrl #(.FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ex_req(wb_ex_req),
        .wb_ex_code(wb_ex_code), .wb_pc(wb_pc), .wb_bd(wb_bd), .wb_eret(wb_eret),
        .cp0_ie(cp0_ie), .cp0_exl(cp0_exl), .cp0_int_mask(cp0_int_mask),
        .cp0_int_sig(cp0_int_sig), .cp0_hlt(cp0_hlt), .resume_req(resume_req),
        .ex_wb_out(ex_wb_out), .ex_code_out(ex_code_out), .epc_out(epc_out),
        .bd_out(bd_out), .eret_flush_out(eret_flush_out), .pipe_flush(pipe_flush),
        .pipe_stall(pipe_stall), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, commits = 0;

    // Model: "left" = cycles of the flush window still to run, incl. current.
    int          left = 0;
    bit          halted = 0, halt_commit = 0;
    logic [42:0] exp_vec = '0;

    function automatic logic [42:0] pack(input logic ex, input logic [4:0] c, input logic [31:0] e,
                                         input logic b, input logic er, input logic fl,
                                         input logic st, input logic bz);
        return {ex, c, e, b, er, fl, st, bz};
    endfunction

    task automatic model_step();
        bit          fire;
        logic [4:0]  c;
        logic [31:0] e;
        logic        b, er;
        fire = 0; c = 0; e = 0; b = 0; er = 0;
        if (!rst) begin
            left = 0; halted = 0; halt_commit = 0; exp_vec = '0;
            return;
        end
        if (left > 0) begin
            left--;
            if (left == 0 && halt_commit) begin
                halted = 1; halt_commit = 0;
            end
        end else if (halted) begin
            if (resume_req) begin fire = 1; c = 5'h02; halted = 0; end
        end else if (wb_valid && wb_ex_req) begin
            fire = 1; c = wb_ex_code; e = wb_pc; b = wb_bd;
        end else if (wb_valid && (|(cp0_int_sig & cp0_int_mask)) && cp0_ie && !cp0_exl && !cp0_hlt) begin
            fire = 1; c = 5'h00; e = wb_pc; b = wb_bd;
        end else if (wb_valid && wb_eret) begin
            fire = 1; er = 1;
        end else if (cp0_hlt && resume_req) begin
            fire = 1; c = 5'h02;
        end
        if (fire) begin
            left = 1 + F;
            halt_commit = !er && (c == 5'h01);
            exp_vec = er ? pack(0, 0, 0, 0, 1, 1, 1, 1) : pack(1, c, e, b, 0, 1, 1, 1);
        end else if (left > 0) exp_vec = pack(0, 0, 0, 0, 0, 1, 1, 1);
        else if (halted)       exp_vec = pack(0, 0, 0, 0, 0, 0, 1, 1);
        else                   exp_vec = '0;
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        model_step();
    end

    initial forever begin
        logic [42:0] got;
        @(negedge clk);
        got = {ex_wb_out, ex_code_out, epc_out, bd_out, eret_flush_out, pipe_flush, pipe_stall, busy};
        tests++;
        if (got !== exp_vec) begin
            fails++;
            $display("FAIL cycle_model t=%0t got=%h required=%h", $time, got, exp_vec);
        end
        if (ex_wb_out === 1'b1) commits++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = 0; wb_ex_req = 0; wb_ex_code = 0; wb_pc = 0; wb_bd = 0; wb_eret = 0;
        cp0_ie = 0; cp0_exl = 0; cp0_int_mask = 0; cp0_int_sig = 0;
    endtask

    task automatic drive_ex(input logic [4:0] code, input logic [31:0] pc, input logic bd);
        wb_valid = 1; wb_ex_req = 1; wb_ex_code = code; wb_pc = pc; wb_bd = bd;
    endtask

    int c0;

    initial begin
        #2 rst = 0;
        repeat (2) step();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_outs", {24'd0, ex_wb_out, ex_code_out, eret_flush_out, pipe_flush}, 32'd0);
        rst = 1;
        step();

        // Overflow exception
        drive_ex(5'h0c, 32'h0040_0100, 1'b0);
        step();
        clear_wb();
        chk("ov_ex", {31'd0, ex_wb_out}, 32'd1);
        chk("ov_code", {27'd0, ex_code_out}, 32'h0c);
        chk("ov_epc", epc_out, 32'h0040_0100);
        chk("ov_flush0", {31'd0, pipe_flush}, 32'd1);
        step();
        chk("ov_drain_ex", {31'd0, ex_wb_out}, 32'd0);
        chk("ov_flush1", {31'd0, pipe_flush}, 32'd1);
        step();
        chk("ov_flush2", {31'd0, pipe_flush}, 32'd1);
        step();
        chk("ov_flush_end", {30'd0, pipe_flush, busy}, 32'd0);

        // Interrupt, then the same with EXL set
        cp0_ie = 1; cp0_exl = 0; cp0_int_mask = 8'hff; cp0_int_sig = 8'h04;
        wb_valid = 1; wb_pc = 32'h0040_0020; wb_bd = 1;
        step();
        clear_wb();
        chk("int_ex", {31'd0, ex_wb_out}, 32'd1);
        chk("int_code", {27'd0, ex_code_out}, 32'h00);
        chk("int_epc", epc_out, 32'h0040_0020);
        chk("int_bd", {31'd0, bd_out}, 32'd1);
        repeat (3) step();
        c0 = commits;
        cp0_ie = 1; cp0_exl = 1; cp0_int_mask = 8'hff; cp0_int_sig = 8'h04;
        wb_valid = 1; wb_pc = 32'h0040_0020; wb_bd = 1;
        repeat (3) step();
        chk("exl_busy", {31'd0, busy}, 32'd0);
        chk("exl_no_commit", commits - c0, 32'd0);
        clear_wb();
        step();

        // ERET together with a syscall, then ERET alone
        drive_ex(5'h08, 32'h0040_0200, 1'b0);
        wb_eret = 1;
        step();
        clear_wb();
        chk("sys_ex", {31'd0, ex_wb_out}, 32'd1);
        chk("sys_code", {27'd0, ex_code_out}, 32'h08);
        chk("sys_no_eret", {31'd0, eret_flush_out}, 32'd0);
        repeat (3) step();
        wb_valid = 1; wb_eret = 1; wb_pc = 32'h0040_0300;
        step();
        clear_wb();
        chk("eret_flush", {31'd0, eret_flush_out}, 32'd1);
        chk("eret_no_ex", {26'd0, ex_wb_out, ex_code_out}, 32'd0);
        step();
        chk("eret_one_cycle", {31'd0, eret_flush_out}, 32'd0);
        repeat (2) step();

        // Halt, interrupts ignored, then resume
        drive_ex(5'h01, 32'h0040_0400, 1'b0);
        step();
        clear_wb();
        chk("hlt_code", {27'd0, ex_code_out}, 32'h01);
        repeat (3) step();
        chk("hlt_state", {29'd0, pipe_stall, pipe_flush, busy}, 32'b101);
        cp0_hlt = 1;
        cp0_ie = 1; cp0_int_mask = 8'hff; cp0_int_sig = 8'h80;
        drive_ex(5'h0a, 32'h0040_0500, 1'b0);
        c0 = commits;
        repeat (2) step();
        chk("hlt_ignore", commits - c0, 32'd0);
        chk("hlt_stall", {30'd0, pipe_stall, busy}, 32'b11);
        clear_wb();
        resume_req = 1;
        step();
        resume_req = 0;
        cp0_hlt = 0;
        chk("resume_ex", {31'd0, ex_wb_out}, 32'd1);
        chk("resume_code", {27'd0, ex_code_out}, 32'h02);
        chk("resume_epc", epc_out, 32'd0);
        repeat (3) step();
        chk("resume_idle", {31'd0, busy}, 32'd0);

        // Second exception during the drain window is dropped
        c0 = commits;
        drive_ex(5'h04, 32'h0040_0600, 1'b0);
        step();
        drive_ex(5'h05, 32'h0040_0700, 1'b1);
        repeat (2) step();
        clear_wb();
        repeat (2) step();
        chk("window_one_commit", commits - c0, 32'd1);
        chk("window_idle", {31'd0, busy}, 32'd0);

        // Reset asserted during drain
        c0 = commits;
        drive_ex(5'h09, 32'h0040_0800, 1'b0);
        step();
        clear_wb();
        step();
        #2 rst = 0;
        #1;
        chk("rst_mid_outs", {24'd0, ex_wb_out, ex_code_out, pipe_flush, pipe_stall}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        repeat (2) step();
        rst = 1;
        repeat (4) step();
        chk("rst_no_commit", commits - c0, 32'd1);
        chk("rst_idle", {30'd0, busy, pipe_flush}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
